// File: rtl/bloom_stream_matcher.sv
// Streaming Bloom-filter matcher: tests every byte-aligned window against a bit filter.
// Define BLOOM_POS_EN to build the first-hit byte offset logic; otherwise match_pos_o is 0.
module bloom_stream_matcher #(
   parameter int DATA_BYTES  = 8,
   parameter int WIN_BYTES   = 7,
   parameter int FILTER_BITS = 64,
   parameter int NUM_HASH    = 3,
   parameter int POS_W       = 16,
   parameter int CNT_W       = 16,
   localparam int IDX_W      = $clog2(FILTER_BITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid_i,
   input  logic                    in_sop_i,
   input  logic [8*DATA_BYTES-1:0] in_data_i,
   input  logic                    flt_wr_en_i,
   input  logic [IDX_W-1:0]        flt_wr_addr_i,
   input  logic                    flt_wr_bit_i,
   input  logic                    flt_clr_i,
   input  logic                    match_en_i,
   input  logic                    match_clr_i,
   output logic                    match_o,
   output logic [POS_W-1:0]        match_pos_o,
   output logic [CNT_W-1:0]        match_cnt_o
);

   localparam int WW = 8 * WIN_BYTES;
   localparam int HW = 8 * (WIN_BYTES - 1);
   localparam int EW = 8 * DATA_BYTES + HW;

   // Rotating by r then folding: bit b lands in fold lane ((b + r) mod WW) mod IDX_W.
   function automatic logic [IDX_W-1:0] hash_idx(input logic [WW-1:0] w, input int k);
      logic [IDX_W-1:0] h;
      int               r;
      h = '0;
      r = (5 * k) % WW;
      for (int b = 0; b < WW; b++) begin
         h[((b + r) % WW) % IDX_W] ^= w[b];
      end
      return h;
   endfunction

   logic [8*DATA_BYTES-1:0] beat_q;
   logic [HW-1:0]           hist_q;
   logic                    hist_vld_q;
   logic                    prev_vld_q;
   logic                    s1_vld_q;
   logic [FILTER_BITS-1:0]  flt_q;
   logic                    match_q, match_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W:0]          cnt_sum;
   logic [CNT_W:0]          pop;
   logic [DATA_BYTES-1:0]   hits;
   logic [EW-1:0]           ext;
   logic [WW-1:0]           win;
   logic                    ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q     <= '0;
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
         prev_vld_q <= 1'b0;
         s1_vld_q   <= 1'b0;
      end else begin
         s1_vld_q <= in_valid_i;
         if (in_valid_i) begin
            beat_q     <= in_data_i;
            hist_q     <= beat_q[8*DATA_BYTES-1 -: HW];
            hist_vld_q <= prev_vld_q & ~in_sop_i;
            prev_vld_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flt_q <= '0;
      end else if (flt_clr_i) begin
         flt_q <= '0;
      end else if (flt_wr_en_i) begin
         flt_q[flt_wr_addr_i] <= flt_wr_bit_i;
      end
   end

   // History bytes precede the beat, so they sit below it: window j is ext[8j +: WW].
   assign ext = {beat_q, hist_q};

   always_comb begin
      hits = '0;
      win  = '0;
      ok   = 1'b0;
      for (int j = 0; j < DATA_BYTES; j++) begin
         win = ext[8*j +: WW];
         ok  = s1_vld_q & match_en_i & ((j >= WIN_BYTES - 1) | hist_vld_q);
         for (int k = 0; k < NUM_HASH; k++) begin
            ok = ok & flt_q[hash_idx(win, k)];
         end
         hits[j] = ok;
      end
   end

   always_comb begin
      pop = '0;
      for (int j = 0; j < DATA_BYTES; j++) begin
         pop = pop + (CNT_W+1)'(hits[j]);
      end
   end

   // A coincident clear wipes the old state, then the hit loads on top of it.
   always_comb begin
      match_d = match_clr_i ? 1'b0 : match_q;
      cnt_d   = match_clr_i ? '0 : cnt_q;
      cnt_sum = {1'b0, cnt_d} + pop;
      if (|hits) begin
         match_d = 1'b1;
         cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match_o     = match_q;
   assign match_cnt_o = cnt_q;

`ifdef BLOOM_POS_EN
   logic [POS_W-1:0] base_q, base_d;
   logic [POS_W:0]   base_sum;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [POS_W-1:0] first_off;

   // Start offset of the window ending at beat byte j, clamped to [0, all-ones].
   function automatic logic [POS_W-1:0] win_off(input logic [POS_W-1:0] base, input int j);
      logic [POS_W:0] s;
      s = {1'b0, base} + (POS_W+1)'(j);
      if (s < (POS_W+1)'(WIN_BYTES - 1)) return '0;
      s = s - (POS_W+1)'(WIN_BYTES - 1);
      return s[POS_W] ? '1 : s[POS_W-1:0];
   endfunction

   always_comb begin
      base_sum = {1'b0, base_q} + (POS_W+1)'(DATA_BYTES);
      base_d   = base_q;
      if (in_valid_i) begin
         if (in_sop_i || !prev_vld_q) base_d = '0;
         else                         base_d = base_sum[POS_W] ? '1 : base_sum[POS_W-1:0];
      end
   end

   always_comb begin
      first_off = '0;
      for (int j = DATA_BYTES - 1; j >= 0; j--) begin
         if (hits[j]) first_off = win_off(base_q, j);
      end
      pos_d = match_clr_i ? '0 : pos_q;
      if ((|hits) && !(match_q && !match_clr_i)) pos_d = first_off;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
         pos_q  <= '0;
      end else begin
         base_q <= base_d;
         pos_q  <= pos_d;
      end
   end

   assign match_pos_o = pos_q;
`else
   assign match_pos_o = '0;
`endif

endmodule

// File: tb/tb_bloom_stream_matcher.sv
// Self-checking bench for bloom_stream_matcher: directed scenarios plus randomized
// traffic compared against a byte-stream reference model.
module tb_bloom_stream_matcher;

   localparam int DB = 8;
   localparam int WB = 7;
   localparam int FB = 64;
   localparam int NH = 3;
   localparam int IW = 6;
   localparam int MAXV = 65535;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_sop;
   logic [63:0]   in_data;
   logic          flt_wr_en;
   logic [IW-1:0] flt_wr_addr;
   logic          flt_wr_bit;
   logic          flt_clr;
   logic          match_en;
   logic          match_clr;
   logic          match;
   logic [15:0]   match_pos;
   logic [15:0]   match_cnt;

   int compared;
   int mismatched;

   bloom_stream_matcher dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid_i    (in_valid),
      .in_sop_i      (in_sop),
      .in_data_i     (in_data),
      .flt_wr_en_i   (flt_wr_en),
      .flt_wr_addr_i (flt_wr_addr),
      .flt_wr_bit_i  (flt_wr_bit),
      .flt_clr_i     (flt_clr),
      .match_en_i    (match_en),
      .match_clr_i   (match_clr),
      .match_o       (match),
      .match_pos_o   (match_pos),
      .match_cnt_o   (match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          ref_flt[FB];
   bit          m_match;
   int          m_pos;
   int          m_cnt;
   bit          have_prev;
   int          total;
   logic [7:0]  tail[$];
   logic [55:0] pend_w[$];
   int          pend_off[$];

   function automatic int ref_hash(input logic [55:0] w, input int k);
      logic [55:0] r;
      int          h;
      int          sh;
      sh = 5 * k;
      r  = (sh == 0) ? w : ((w << sh) | (w >> (56 - sh)));
      h  = 0;
      for (int s = 0; s * IW < 56; s++) h = h ^ int'((r >> (s * IW)) & 56'(FB - 1));
      return h;
   endfunction

   function automatic int exp_pos();
`ifdef BLOOM_POS_EN
      return m_pos;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < FB; i++) ref_flt[i] = 1'b0;
      m_match = 1'b0; m_pos = 0; m_cnt = 0;
      have_prev = 1'b0; total = 0;
      tail.delete(); pend_w.delete(); pend_off.delete();
   endtask

   // One rising edge: evaluate last beat's windows, update filter, absorb this beat.
   task automatic model_edge(input logic v, input logic sop, input logic [63:0] d,
                             input logic men, input logic mclr, input logic fclr,
                             input logic fwe, input logic [IW-1:0] fa, input logic fb);
      int hits, first, base, off;
      bit ok;
      logic [55:0] w;
      hits = 0; first = -1;
      foreach (pend_w[i]) begin
         ok = 1'b1;
         for (int k = 0; k < NH; k++) if (!ref_flt[ref_hash(pend_w[i], k)]) ok = 1'b0;
         if (ok) begin
            hits++;
            if (first < 0) first = pend_off[i];
         end
      end
      if (!men) hits = 0;
      if (mclr) begin m_match = 1'b0; m_pos = 0; m_cnt = 0; end
      if (hits > 0) begin
         if (!m_match) m_pos = first;
         m_match = 1'b1;
         m_cnt = (m_cnt + hits > MAXV) ? MAXV : m_cnt + hits;
      end
      pend_w.delete(); pend_off.delete();
      if (fclr) for (int i = 0; i < FB; i++) ref_flt[i] = 1'b0;
      else if (fwe) ref_flt[fa] = fb;
      if (v) begin
         if (sop || !have_prev) begin tail.delete(); total = 0; end
         base = (total > MAXV) ? MAXV : total;
         for (int j = 0; j < DB; j++) begin
            tail.push_back(d[8*j +: 8]);
            if (tail.size() >= WB) begin
               w = '0;
               for (int i = 0; i < WB; i++) w[8*i +: 8] = tail[tail.size() - WB + i];
               off = base + j - (WB - 1);
               if (off < 0) off = 0;
               if (off > MAXV) off = MAXV;
               pend_w.push_back(w);
               pend_off.push_back(off);
            end
            while (tail.size() > WB - 1) void'(tail.pop_front());
         end
         total += DB;
         have_prev = 1'b1;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic v, input logic sop, input logic [63:0] d,
                       input logic men, input logic mclr, input logic fclr,
                       input logic fwe, input logic [IW-1:0] fa, input logic fb);
      in_valid = v; in_sop = sop; in_data = d; match_en = men; match_clr = mclr;
      flt_clr = fclr; flt_wr_en = fwe; flt_wr_addr = fa; flt_wr_bit = fb;
      @(posedge clk);
      model_edge(v, sop, d, men, mclr, fclr, fwe, fa, fb);
      #1;
   endtask

   task automatic idle(input logic men);
      step(1'b0, 1'b0, 64'd0, men, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic set_bit0();
      step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b1);
   endtask

   task automatic clear_match();
      step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      in_valid = 0; in_sop = 0; in_data = '0; match_en = 0; match_clr = 0;
      flt_clr = 0; flt_wr_en = 0; flt_wr_addr = '0; flt_wr_bit = 0;
      model_reset();
      #2;
      compared++;
      if (match !== 1'b0) begin mismatched++; $display("FAIL reset_match: got %0b want 0", match); end
      compared++;
      if (match_pos !== 16'd0) begin mismatched++; $display("FAIL reset_pos: got %0d want 0", match_pos); end
      compared++;
      if (match_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_hit();
      set_bit0();
      step(1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b1);
      compared++;
      if (match !== 1'b1) begin mismatched++; $display("FAIL zero_match: got %0b want 1", match); end
      compared++;
      if (match_pos !== 16'd0) begin mismatched++; $display("FAIL zero_pos: got %0d want 0", match_pos); end
      compared++;
      if (match_cnt !== 16'd2) begin mismatched++; $display("FAIL zero_cnt: got %0d want 2", match_cnt); end
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b1);
      compared++;
      if (match_cnt !== 16'd10) begin mismatched++; $display("FAIL zero_cnt2: got %0d want 10", match_cnt); end
      compared++;
      if (match_pos !== 16'd0) begin mismatched++; $display("FAIL zero_pos2: got %0d want 0", match_pos); end
   endtask

   task automatic test_match_en();
      clear_match();
      step(1'b1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b0);
      step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b0);
      compared++;
      if (match !== 1'b0) begin mismatched++; $display("FAIL en_off_match: got %0b want 0", match); end
      compared++;
      if (match_cnt !== 16'd0) begin mismatched++; $display("FAIL en_off_cnt: got %0d want 0", match_cnt); end
      step(1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b1);
      compared++;
      if (match_cnt !== 16'd2) begin mismatched++; $display("FAIL sop_boundary_cnt: got %0d want 2", match_cnt); end
   endtask

   task automatic test_filter_clr();
      logic [63:0] d;
      step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         d = (i % 4 == 0) ? 64'd0 : {$urandom, $urandom};
         step(1'($urandom_range(0, 3) != 0), 1'(i % 5 == 0), d, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
         compared++;
         if (match !== 1'b0) begin
            mismatched++; $display("FAIL empty_filter_match cycle %0d: got %0b want 0", i, match);
         end
      end
      idle(1'b1);
      compared++;
      if (match_cnt !== 16'd0) begin mismatched++; $display("FAIL empty_filter_cnt: got %0d want 0", match_cnt); end
   endtask

   task automatic test_back_to_back();
      set_bit0();
      clear_match();
      step(1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      compared++;
      if (match !== 1'b1) begin mismatched++; $display("FAIL clr_hit_match: got %0b want 1", match); end
      compared++;
      if (match_cnt !== 16'd8) begin mismatched++; $display("FAIL clr_hit_cnt: got %0d want 8", match_cnt); end
      compared++;
      if (int'(match_pos) !== exp_pos()) begin
         mismatched++; $display("FAIL clr_hit_pos: got %0d want %0d", match_pos, exp_pos());
      end
      clear_match();
      step(1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int b = 1; b < 8200; b++) begin
         step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
         if (b % 1024 == 0) begin
            compared++;
            if (int'(match_cnt) !== m_cnt) begin
               mismatched++; $display("FAIL stream_cnt beat %0d: got %0d want %0d", b, match_cnt, m_cnt);
            end
         end
      end
      idle(1'b1);
      compared++;
      if (match_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_cnt: got %0d want 65535", match_cnt); end
      compared++;
      if (int'(match_pos) !== exp_pos()) begin
         mismatched++; $display("FAIL sat_pos: got %0d want %0d", match_pos, exp_pos());
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      compared++;
      if (match !== 1'b0) begin mismatched++; $display("FAIL rst_mid_match: got %0b want 0", match); end
      compared++;
      if (match_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_mid_cnt: got %0d want 0", match_cnt); end
      compared++;
      if (match_pos !== 16'd0) begin mismatched++; $display("FAIL rst_mid_pos: got %0d want 0", match_pos); end
      @(negedge clk);
      rst = 1'b0;
      set_bit0();
      step(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      idle(1'b1);
      compared++;
      if (match_cnt !== 16'd2) begin mismatched++; $display("FAIL rst_nosop_cnt: got %0d want 2", match_cnt); end
      compared++;
      if (match_pos !== 16'd0) begin mismatched++; $display("FAIL rst_nosop_pos: got %0d want 0", match_pos); end
   endtask

   task automatic test_random();
      logic [63:0] d;
      for (int i = 0; i < FB; i++)
         step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, IW'(i), 1'($urandom_range(0, 6) != 0));
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < DB; b++) d[8*b +: 8] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
         step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 6) == 0), d,
              1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) == 0),
              IW'($urandom_range(0, FB - 1)), 1'($urandom_range(0, 3) != 0));
         compared++;
         if (match !== m_match) begin
            mismatched++; $display("FAIL rand_match cycle %0d: got %0b want %0b", c, match, m_match);
         end
         compared++;
         if (int'(match_cnt) !== m_cnt) begin
            mismatched++; $display("FAIL rand_cnt cycle %0d: got %0d want %0d", c, match_cnt, m_cnt);
         end
         compared++;
         if (int'(match_pos) !== exp_pos()) begin
            mismatched++; $display("FAIL rand_pos cycle %0d: got %0d want %0d", c, match_pos, exp_pos());
         end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_zero_hit();
      test_match_en();
      test_filter_clr();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
